// File: rtl/mips_sim_pkg.sv
// Shared state encoding, end-of-run causes and default constants for the
// MIPS run controller.
package mips_sim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      END_NONE    = 2'd0,
      END_HALT    = 2'd1,
      END_STALL   = 2'd2,
      END_TIMEOUT = 2'd3
   } end_cause_t;

   localparam int unsigned DEF_RESET_CYCLES = 5;
   localparam int unsigned DEF_MAX_CYCLES   = 1000;
   localparam int unsigned DEF_STALL_LIMIT  = 8;
   localparam logic [31:0] DEF_HALT_PC      = 32'h0000_3000;

   // Hold counter width covers the full legal RESET_CYCLES range of 1..255.
   localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/pc_stall_det.sv
// Watches the CPU program counter during a run and flags a stall once the
// same valid pc has been seen STALL_LIMIT times in a row.
module pc_stall_det
   import mips_sim_pkg::*;
#(
   parameter int unsigned PC_W        = 32,
   parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [PC_W-1:0] pc,
   input  logic            pc_valid,
   output logic            stall_hit
);

   localparam int unsigned SC_W = $clog2(STALL_LIMIT) + 1;

   logic [PC_W-1:0] prev_pc;
   logic            prev_ok;
   logic [SC_W-1:0] rpt_cnt;
   logic            is_repeat;

   // prev_ok is cleared outside a run, so the first valid pc of a run never matches.
   assign is_repeat = en && pc_valid && prev_ok && (pc == prev_pc);
   assign stall_hit = is_repeat && (rpt_cnt >= SC_W'(STALL_LIMIT - 2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_pc <= '0;
         prev_ok <= 1'b0;
         rpt_cnt <= '0;
      end else if (!en) begin
         prev_pc <= '0;
         prev_ok <= 1'b0;
         rpt_cnt <= '0;
      end else begin
         if (pc_valid) begin
            prev_pc <= pc;
            prev_ok <= 1'b1;
         end
         if (!is_repeat)
            rpt_cnt <= '0;
         else if (rpt_cnt != '1)
            rpt_cnt <= rpt_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for a simulated MIPS core: holds the CPU in reset, lets it run,
// and ends the run on halt pc, pc stall or cycle budget exhaustion.
//
// state  | meaning
// IDLE   | waiting for start, CPU held in reset
// HOLD   | CPU reset asserted for RESET_CYCLES cycles
// RUN    | CPU released, cycles counted, end conditions watched
// FINISH | run ended, done plus one cause flag, count frozen
module mips_run_ctrl
   import mips_sim_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
   parameter int unsigned STALL_LIMIT  = DEF_STALL_LIMIT,
   parameter int unsigned PC_W         = 32,
   parameter int unsigned CNT_W        = 32,
   parameter logic [PC_W-1:0] HALT_PC  = PC_W'(DEF_HALT_PC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  pc,
   input  logic             pc_valid,
   output logic             cpu_reset,
   output logic             running,
   output logic             done,
   output logic             halted,
   output logic             timeout,
   output logic             stalled,
   output logic [CNT_W-1:0] cycle_count
);

   run_state_t        state;
   run_state_t        state_nxt;
   end_cause_t        cause;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic              halt_hit;
   logic              stall_hit;
   logic              tmo_hit;
   logic              launch;

   pc_stall_det #(
      .PC_W        (PC_W),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall (
      .clk       (clk),
      .reset     (reset),
      .en        (running),
      .pc        (pc),
      .pc_valid  (pc_valid),
      .stall_hit (stall_hit)
   );

   // cnt_inc is the count including the current RUN cycle.
   assign cnt_inc  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
   assign halt_hit = pc_valid && (pc == HALT_PC);
   assign tmo_hit  = (cnt_inc >= CNT_W'(MAX_CYCLES));
   assign launch   = start && (state != ST_HOLD);

   always_comb begin
      cause = END_NONE;
      if (state == ST_RUN) begin
         if (halt_hit)
            cause = END_HALT;
         else if (stall_hit)
            cause = END_STALL;
         else if (tmo_hit)
            cause = END_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start) state_nxt = ST_HOLD;
         ST_HOLD:   if (hold_cnt <= HOLD_W'(1)) state_nxt = ST_RUN;
         ST_RUN: begin
            if (start)
               state_nxt = ST_HOLD;
            else if (cause != END_NONE)
               state_nxt = ST_FINISH;
         end
         ST_FINISH: if (start) state_nxt = ST_HOLD;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_reset = (state != ST_RUN);
      running   = (state == ST_RUN);
      done      = (state == ST_FINISH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt    <= '0;
         cycle_count <= '0;
         halted      <= 1'b0;
         stalled     <= 1'b0;
         timeout     <= 1'b0;
      end else if (launch) begin
         hold_cnt    <= HOLD_W'(RESET_CYCLES);
         cycle_count <= '0;
         halted      <= 1'b0;
         stalled     <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         if (state == ST_HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
         if (state == ST_RUN) begin
            cycle_count <= cnt_inc;
            halted      <= (cause == END_HALT);
            stalled     <= (cause == END_STALL);
            timeout     <= (cause == END_TIMEOUT);
         end
      end
   end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench: two controllers (default budget and MAX_CYCLES=20) share
// stimulus; expected end-of-run results are queued and checked when done rises.
module tb_mips_run_ctrl;

   typedef struct packed {
      logic [2:0]  flags;   // {halted, stalled, timeout}
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] pc;
   logic        pc_valid;

   logic [1:0]  cpu_reset_v;
   logic [1:0]  running_v;
   logic [1:0]  done_v;
   logic [1:0]  halted_v;
   logic [1:0]  timeout_v;
   logic [1:0]  stalled_v;
   logic [31:0] cc [2];

   exp_t qa[$];
   exp_t qb[$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_run_ctrl u_a (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .cpu_reset   (cpu_reset_v[0]),
      .running     (running_v[0]),
      .done        (done_v[0]),
      .halted      (halted_v[0]),
      .timeout     (timeout_v[0]),
      .stalled     (stalled_v[0]),
      .cycle_count (cc[0])
   );

   mips_run_ctrl #(.MAX_CYCLES(20)) u_b (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .cpu_reset   (cpu_reset_v[1]),
      .running     (running_v[1]),
      .done        (done_v[1]),
      .halted      (halted_v[1]),
      .timeout     (timeout_v[1]),
      .stalled     (stalled_v[1]),
      .cycle_count (cc[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pop one expected result per rising done, per instance.
   logic [1:0] done_q = 2'b00;
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (done_v[i] && !done_q[i]) begin
            if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done inst=%0d count=%0d", i, cc[i]);
            end else begin
               if (i == 0) e = qa.pop_front();
               else        e = qb.pop_front();
               chk($sformatf("end_flags%0d", i), {29'd0, halted_v[i], stalled_v[i], timeout_v[i]}, {29'd0, e.flags});
               chk($sformatf("end_count%0d", i), cc[i], e.cnt);
            end
         end else if (!done_v[i]) begin
            chk($sformatf("flags_clear%0d", i), {29'd0, halted_v[i], stalled_v[i], timeout_v[i]}, 32'd0);
         end
      end
      done_q <= done_v;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_cpu_reset", {30'd0, cpu_reset_v}, 32'd3);
      chk("rst_running",   {30'd0, running_v},   32'd0);
      chk("rst_done",      {30'd0, done_v},      32'd0);
      chk("rst_flags",     {26'd0, halted_v, timeout_v, stalled_v}, 32'd0);
      chk("rst_count0",    cc[0], 32'd0);
      chk("rst_count1",    cc[1], 32'd0);
   endtask

   // Pulse start, then expect exactly 5 HOLD cycles with flags and count cleared.
   task automatic launch();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int h = 0; h < 5; h++) begin
         chk("hold_cpu_reset", {30'd0, cpu_reset_v}, 32'd3);
         chk("hold_running",   {30'd0, running_v},   32'd0);
         chk("hold_done",      {30'd0, done_v},      32'd0);
         chk("hold_count0",    cc[0], 32'd0);
         chk("hold_count1",    cc[1], 32'd0);
         step();
      end
      chk("run_cpu_reset", {30'd0, cpu_reset_v}, 32'd0);
      chk("run_running",   {30'd0, running_v},   32'd3);
   endtask

   // kind 0: pc ramps by 4 to HALT_PC at cycle halt_k; 1: pc = 4k; 2: pc = 4k then 3010 from cycle 10
   task automatic run_pc(input int n, input int kind, input int halt_k);
      for (int k = 1; k <= n; k++) begin
         case (kind)
            0:       pc = 32'h0000_3000 - 32'(4 * (halt_k - k));
            1:       pc = 32'(4 * k);
            default: pc = (k >= 10) ? 32'h0000_3010 : 32'(4 * k);
         endcase
         pc_valid = 1'b1;
         step();
      end
      pc_valid = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      pc       = '0;
      pc_valid = 1'b0;
      #1;
      chk_reset_vals();
      step();
      step();
      reset = 1'b1;
      step();
      step();
      chk("idle_after_release", {28'd0, cpu_reset_v, running_v}, 32'b1100);

      // Halt at RUN cycle 40; the 20-cycle instance times out first.
      qa.push_back(exp_t'{3'b100, 32'd40});
      qb.push_back(exp_t'{3'b001, 32'd20});
      launch();
      run_pc(40, 0, 40);
      step();

      // Timeout with pc never reaching HALT_PC.
      qb.push_back(exp_t'{3'b001, 32'd20});
      launch();
      run_pc(20, 1, 0);
      chk("tmo_running_b", {31'd0, running_v[1]}, 32'd0);
      chk("tmo_flag_b",    {31'd0, timeout_v[1]}, 32'd1);
      chk("tmo_running_a", {31'd0, running_v[0]}, 32'd1);
      step();

      // pc stuck at 3010 from cycle 10: 8 equal samples end at cycle 17.
      qa.push_back(exp_t'{3'b010, 32'd17});
      qb.push_back(exp_t'{3'b010, 32'd17});
      launch();
      run_pc(17, 2, 0);
      step();

      // Halt on the same cycle the 20-cycle budget runs out.
      qa.push_back(exp_t'{3'b100, 32'd20});
      qb.push_back(exp_t'{3'b100, 32'd20});
      launch();
      run_pc(20, 0, 20);
      step();

      // Restart at RUN cycle 15, then halt at cycle 10 of the new run.
      launch();
      run_pc(14, 1, 0);
      pc       = 32'd60;
      pc_valid = 1'b1;
      qa.push_back(exp_t'{3'b100, 32'd10});
      qb.push_back(exp_t'{3'b100, 32'd10});
      launch();
      run_pc(10, 0, 10);
      step();

      // Asynchronous reset mid-run at RUN cycle 7.
      launch();
      run_pc(6, 1, 0);
      pc       = 32'd28;
      pc_valid = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      chk_reset_vals();
      pc_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("post_rst_idle", {26'd0, cpu_reset_v, running_v, done_v}, 32'b110000);
      end
      chk("post_rst_count", cc[0], 32'd0);

      chk("queue_a_drained", qa.size(), 32'd0);
      chk("queue_b_drained", qb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_CYCLES, 5, cycles cpu_reset is held after start (legal range 1..255)
  MAX_CYCLES, 1000, run-cycle budget before timeout (>=1)
  STALL_LIMIT, 8, consecutive unchanged-PC cycles that declare a stall (>=2)
  PC_W, 32, PC width
  CNT_W, 32, cycle counter width
  HALT_PC, 32'h0000_3000, PC value that ends a run normally
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on the rising edge
  reset  in  1  asynchronous, active-low reset
  start  in  1  one-cycle pulse that begins a run
  pc  in  PC_W  current CPU program counter
  pc_valid  in  1  pc is meaningful this cycle
  cpu_reset  out  1  active-high reset driven to the CPU under control
  running  out  1  a run is in progress (state RUN)
  done  out  1  run ended, sticky until the next start
  halted  out  1  run ended because HALT_PC was reached
  timeout  out  1  run ended because MAX_CYCLES elapsed
  stalled  out  1  run ended because pc held for STALL_LIMIT cycles
  cycle_count  out  CNT_W  cycles spent in RUN for the current or last run

Function
REQ-003 The FSM SHALL have four states: IDLE, HOLD, RUN, FINISH.
REQ-004 IDLE: cpu_reset=1; start=1 SHALL move to HOLD, clear done/halted/timeout/stalled and cycle_count, and load the hold counter with RESET_CYCLES.
REQ-005 HOLD: cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN; start in HOLD SHALL be ignored.
REQ-006 RUN: cpu_reset=0 and running=1; cycle_count SHALL increment by 1 per RUN cycle, saturating at all-ones.
REQ-007 HALT_PC SHALL be detected on any RUN cycle with pc_valid=1 and pc==HALT_PC, setting halted and moving to FINISH next cycle.
REQ-008 A stall counter SHALL increment on each RUN cycle where pc_valid=1 and pc equals the previous valid pc, and reset to 0 otherwise; reaching STALL_LIMIT-1 SHALL set stalled and go to FINISH.
REQ-009 When cycle_count reaches MAX_CYCLES, timeout SHALL be set and the FSM SHALL go to FINISH.
REQ-010 Simultaneous end conditions SHALL set only one flag, priority halted > stalled > timeout.
REQ-011 FINISH: cpu_reset=1, running=0, done=1, and cycle_count frozen; start=1 SHALL begin a new run exactly as from IDLE.
REQ-012 start asserted in RUN SHALL abort the run and restart in HOLD with all flags cleared.
REQ-013 The first valid pc after entering RUN SHALL never count as a repeat.
REQ-014 Exactly one of halted/stalled/timeout SHALL be 1 whenever done=1; all three SHALL be 0 whenever done=0.

Reset
REQ-015 reset=0 SHALL asynchronously force IDLE, cpu_reset=1, running=0, done=halted=timeout=stalled=0, cycle_count=0, and all internal counters to 0, including mid-HOLD or mid-RUN.
REQ-016 Reset release SHALL take effect on the next rising clk edge; no run SHALL start without a start pulse.

Structure
REQ-017 The state encoding and the default constants (RESET_CYCLES, MAX_CYCLES, STALL_LIMIT, HALT_PC) SHALL live in a shared package, mips_sim_pkg.
REQ-018 The PC stall detector (previous-pc register plus repeat counter) SHALL be a single sub-module, pc_stall_det; everything else SHALL stay in mips_run_ctrl.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  Defaults, start at t0, pc steps +4 until it reaches 32'h3000 at RUN cycle 40 -> cpu_reset high for 5 cycles, halted=1, done=1, cycle_count=40.
  MAX_CYCLES=20, pc keeps incrementing and never reaches HALT_PC -> timeout=1 at cycle_count=20, running=0 on the next cycle.
  pc held at 32'h0000_3010 from RUN cycle 10 -> stalled=1 after 8 equal valid samples, halted=timeout=0.
  pc reaches HALT_PC on the same cycle cycle_count hits MAX_CYCLES -> halted=1, timeout=0.
  reset pulled low at RUN cycle 7 -> outputs return to reset values immediately, no clock required; the FSM stays in IDLE until start.
  start re-pulsed at RUN cycle 15 -> flags cleared, 5 HOLD cycles, cycle_count restarts at 0.
